// File: rtl/clk_div_sel.sv
// Selectable clock divider with glitch-free ratio switching at period edges.
// Optional macro CLKDIV_DIRECT_EN adds a direct ratio request port.
module clk_div_sel #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [5:0]       PRESCALE,
`ifdef CLKDIV_DIRECT_EN
  input  logic [WIDTH-1:0] RATIO_DIRECT,
`endif
  output logic             DIV_CLK,
  output logic [WIDTH-1:0] RATIO,
  output logic             RATIO_UPD
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [31:0]      MAXR = (32'd1 << WIDTH) - 32'd1;

  logic [WIDTH-1:0] cnt;
  logic             div_q;
  logic [31:0]      req32;
  logic [WIDTH-1:0] req;
  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] cnt_inc;
  logic             multi;
  logic             wrap;
  logic             boundary;

  always_comb begin
    req32 = 32'd1;
    case (PRESCALE)
      6'b100000: req32 = 32'd1;
      6'b010000: req32 = 32'd2;
      6'b001000: req32 = 32'd4;
      6'b000100: req32 = 32'd8;
      6'b000010: req32 = 32'd16;
      6'b000001: req32 = 32'd32;
`ifdef CLKDIV_DIRECT_EN
      6'b000000: req32 = (RATIO_DIRECT > ONE) ? 32'(RATIO_DIRECT) : 32'd1;
`endif
      default:   req32 = 32'd1;
    endcase
    // Ratios the counter cannot represent fall back to bypass
    req = (req32 > MAXR) ? ONE : req32[WIDTH-1:0];
  end

  assign half     = RATIO >> 1;
  assign multi    = RATIO > ONE;
  assign cnt_inc  = cnt + ONE;
  assign wrap     = cnt == (RATIO - ONE);
  assign boundary = EN & (~multi | wrap);

  assign DIV_CLK = (EN && multi) ? div_q : CLK;

  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      cnt       <= '0;
      div_q     <= 1'b0;
      RATIO     <= ONE;
      RATIO_UPD <= 1'b0;
    end else if (boundary) begin
      // New period always opens with a full high phase
      cnt       <= '0;
      div_q     <= req > ONE;
      RATIO     <= req;
      RATIO_UPD <= req != RATIO;
    end else begin
      cnt       <= cnt_inc;
      div_q     <= cnt_inc < half;
      RATIO_UPD <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_div_sel.sv
// Directed bench for clk_div_sel (WIDTH=8 and WIDTH=5 instances).
// Define CLKDIV_DIRECT_EN to also exercise the direct ratio port.
module tb_clk_div_sel;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic [5:0] PRESCALE;
  logic       dclk8, upd8, dclk5, upd5;
  logic [7:0] ratio8;
  logic [4:0] ratio5;
`ifdef CLKDIV_DIRECT_EN
  logic [7:0] rd8;
  logic [4:0] rd5;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  clk_div_sel #(.WIDTH(8)) u8 (
    .CLK(CLK), .RST(RST), .EN(EN), .PRESCALE(PRESCALE),
`ifdef CLKDIV_DIRECT_EN
    .RATIO_DIRECT(rd8),
`endif
    .DIV_CLK(dclk8), .RATIO(ratio8), .RATIO_UPD(upd8)
  );

  clk_div_sel #(.WIDTH(5)) u5 (
    .CLK(CLK), .RST(RST), .EN(EN), .PRESCALE(PRESCALE),
`ifdef CLKDIV_DIRECT_EN
    .RATIO_DIRECT(rd5),
`endif
    .DIV_CLK(dclk5), .RATIO(ratio5), .RATIO_UPD(upd5)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1;
    EN = 1'b0;
    PRESCALE = 6'b000000;
`ifdef CLKDIV_DIRECT_EN
    rd8 = 8'd0;
    rd5 = 5'd0;
`endif
    step();
    step();
    chk("rst_ratio", 32'(ratio8), 32'd1);
    chk("rst_upd", 32'(upd8), 32'd0);
    chk("rst_byp_hi", 32'(dclk8), 32'd1);
    @(negedge CLK); #1;
    chk("rst_byp_lo", 32'(dclk8), 32'd0);

    // ratio 4 from reset: first edge is a boundary
    RST = 1'b0;
    EN = 1'b1;
    PRESCALE = 6'b001000;
    step();
    chk("r4_ratio", 32'(ratio8), 32'd4);
    chk("r4_upd", 32'(upd8), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      chk("r4_wave", 32'(dclk8), (i % 4) < 2 ? 32'd1 : 32'd0);
      if (i > 0) chk("r4_noupd", 32'(upd8), 32'd0);
    end

    // at cnt=3 of N=4: next edge switches to 8
    PRESCALE = 6'b000100;
    step();
    chk("r8_ratio", 32'(ratio8), 32'd8);
    chk("r8_upd", 32'(upd8), 32'd1);
    chk("r8_hi0", 32'(dclk8), 32'd1);
    step();
    step();
    // cnt=2: transient request then final request before wrap
    PRESCALE = 6'b000010;
    step();
    PRESCALE = 6'b010000;
    chk("r8_hold3", 32'(ratio8), 32'd8);
    chk("r8_hi3", 32'(dclk8), 32'd1);
    for (int k = 4; k < 8; k++) begin
      step();
      chk("r8_hold", 32'(ratio8), 32'd8);
      chk("r8_lo", 32'(dclk8), 32'd0);
      chk("r8_noupd", 32'(upd8), 32'd0);
    end
    step();
    chk("r2_ratio", 32'(ratio8), 32'd2);
    chk("r2_upd", 32'(upd8), 32'd1);
    chk("r2_hi", 32'(dclk8), 32'd1);
    step();
    chk("r2_lo", 32'(dclk8), 32'd0);
    chk("r2_noupd", 32'(upd8), 32'd0);

    // illegal code falls back to bypass
    PRESCALE = 6'b000011;
    step();
    chk("ill_ratio", 32'(ratio8), 32'd1);
    chk("ill_upd", 32'(upd8), 32'd1);
    chk("ill_byp_hi", 32'(dclk8), 32'd1);
    @(negedge CLK); #1;
    chk("ill_byp_lo", 32'(dclk8), 32'd0);

    // ratio 32: legal at WIDTH=8, out of range at WIDTH=5
    PRESCALE = 6'b000001;
    step();
    chk("r32_ratio8", 32'(ratio8), 32'd32);
    chk("r32_upd8", 32'(upd8), 32'd1);
    chk("r32_ratio5", 32'(ratio5), 32'd1);
    chk("r32_upd5", 32'(upd5), 32'd0);
    chk("r32_byp5", 32'(dclk5), 32'd1);
    step();
    step();
    step();
    // cnt=3 of N=32: reset abandons period
    RST = 1'b1;
    step();
    chk("rstm_ratio", 32'(ratio8), 32'd1);
    chk("rstm_upd", 32'(upd8), 32'd0);
    chk("rstm_byp", 32'(dclk8), 32'd1);
    RST = 1'b0;
    step();
    chk("rstx_ratio", 32'(ratio8), 32'd32);
    chk("rstx_upd", 32'(upd8), 32'd1);

    // move to 16: old 32-cycle period completes first
    PRESCALE = 6'b000010;
    for (int k = 1; k < 32; k++) step();
    chk("r16_hold", 32'(ratio8), 32'd32);
    chk("r16_lo31", 32'(dclk8), 32'd0);
    step();
    chk("r16_ratio", 32'(ratio8), 32'd16);
    chk("r16_upd", 32'(upd8), 32'd1);
    for (int k = 1; k <= 5; k++) step();
    chk("r16_hi5", 32'(dclk8), 32'd1);

    // drop EN at cnt=5
    EN = 1'b0;
    step();
    chk("dis_ratio", 32'(ratio8), 32'd1);
    chk("dis_upd", 32'(upd8), 32'd0);
    chk("dis_byp_hi", 32'(dclk8), 32'd1);
    @(negedge CLK); #1;
    chk("dis_byp_lo", 32'(dclk8), 32'd0);
    step();
    chk("dis_upd2", 32'(upd8), 32'd0);
    EN = 1'b1;
    step();
    chk("ena_ratio", 32'(ratio8), 32'd16);
    chk("ena_upd", 32'(upd8), 32'd1);
    chk("ena_hi", 32'(dclk8), 32'd1);

`ifdef CLKDIV_DIRECT_EN
    PRESCALE = 6'b000000;
    rd8 = 8'd5;
    rd5 = 5'd5;
    for (int k = 1; k < 16; k++) step();
    step();
    chk("d5_ratio", 32'(ratio8), 32'd5);
    chk("d5_upd", 32'(upd8), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      chk("d5_wave", 32'(dclk8), (i % 5) < 2 ? 32'd1 : 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
